ttt_auto_player: RTL and testbench

Automatic opponent for the tic-tac-toe game core. It reads the board-occupancy and result outputs the game drives, and decides a move when it is its player's turn. It then emits that move as a single cell-press pulse on the nine cell-press inputs the game consumes. It sits beside the game core in place of a human on one side, driving the press lines that the bench drives by hand today.

---
 rtl/ttt_pkg.sv | 35 +++
 rtl/ttt_line_eval.sv | 38 +++
 rtl/ttt_auto_player.sv | 194 +++++++++++++++++++
 tb/tb_ttt_auto_player.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types and tables for the tic-tac-toe auto player.
//   state_t        - controller state encoding
//   LINE_TABLE     - the 8 winning lines as 0-based cell triples
//   FALLBACK_ORDER - cell preference when no win/block move exists
//   MOVE_NONE      - move_idx value before any move has been chosen
package ttt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_WIN,
    SCAN_BLOCK,
    FALLBACK,
    PRESS,
    GAP,
    WAIT_ACK
  } state_t;

  localparam logic [3:0] LINE_TABLE [0:7][0:2] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  localparam logic [3:0] FALLBACK_ORDER [0:8] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  localparam logic [3:0] MOVE_NONE = 4'hF;

endpackage

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: combinational evaluation of one winning line.
//   mine, theirs - occupancy of the side being tested and of the other side
//   line         - line index 0..7 into LINE_TABLE
//   hit          - exactly two cells of the line are in mine, the third empty
//   empty_cell   - the empty cell of a hitting line (MOVE_NONE otherwise)
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [8:0] mine,
  input  logic [8:0] theirs,
  input  logic [2:0] line,
  output logic       hit,
  output logic [3:0] empty_cell
);

  logic [3:0] ca, cb, cc;
  logic [2:0] m;
  logic [2:0] e;
  logic [8:0] free;

  always_comb begin
    ca   = LINE_TABLE[line][0];
    cb   = LINE_TABLE[line][1];
    cc   = LINE_TABLE[line][2];
    free = ~(mine | theirs);
    m    = {mine[cc], mine[cb], mine[ca]};
    e    = {free[cc], free[cb], free[ca]};
    hit        = 1'b0;
    empty_cell = MOVE_NONE;
    case (m)
      3'b110: if (e[0]) begin hit = 1'b1; empty_cell = ca; end
      3'b101: if (e[1]) begin hit = 1'b1; empty_cell = cb; end
      3'b011: if (e[2]) begin hit = 1'b1; empty_cell = cc; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ttt_auto_player.sv
// ttt_auto_player: automatic tic-tac-toe opponent.
//   clk, reset (async, active-low)
//   enable, my_player         - move permission and side (sampled in IDLE)
//   board_p1, board_p2        - live board occupancy from the game core
//   win_p1, win_p2, draw      - game result flags
//   press                     - one-hot cell press pulse to the game core
//   busy                      - high whenever not IDLE
//   move_idx                  - last chosen cell (MOVE_NONE before first move)
//   err_illegal               - sticky illegal-board flag
//   err_timeout               - one-cycle pulse when the move is not acknowledged
module ttt_auto_player
  import ttt_pkg::*;
#(
  parameter int PRESS_CYCLES = 4,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       my_player,
  input  logic [8:0] board_p1,
  input  logic [8:0] board_p2,
  input  logic       win_p1,
  input  logic       win_p2,
  input  logic       draw,
  output logic [8:0] press,
  output logic       busy,
  output logic [3:0] move_idx,
  output logic       err_illegal,
  output logic       err_timeout
);

  localparam int CMAX = (PRESS_CYCLES > ACK_TIMEOUT) ? PRESS_CYCLES : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);

  state_t        state, state_n;
  logic [2:0]    line_idx, line_idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0]    snap_p1, snap_p1_n, snap_p2, snap_p2_n;
  logic          me, me_n;
  logic [3:0]    target, target_n;
  logic [3:0]    move_idx_n;
  logic          err_illegal_n, err_timeout_n;

  logic [3:0] n1, n2;
  logic       game_over, board_illegal, my_turn, board_changed;
  logic [8:0] snap_mine, snap_theirs, live_mine, occ;
  logic [8:0] eval_mine, eval_theirs;
  logic       hit;
  logic [3:0] empty_cell;
  logic       fb_found;
  logic [3:0] fb_cell;

  // The block scan reuses the same evaluator with the sides swapped.
  assign eval_mine   = (state == SCAN_BLOCK) ? snap_theirs : snap_mine;
  assign eval_theirs = (state == SCAN_BLOCK) ? snap_mine   : snap_theirs;

  ttt_line_eval u_line_eval (
    .mine       (eval_mine),
    .theirs     (eval_theirs),
    .line       (line_idx),
    .hit        (hit),
    .empty_cell (empty_cell)
  );

  always_comb begin
    n1            = 4'($countones(board_p1));
    n2            = 4'($countones(board_p2));
    game_over     = win_p1 | win_p2 | draw;
    board_illegal = (|(board_p1 & board_p2)) || !((n1 == n2) || (n1 == n2 + 4'd1));
    my_turn       = my_player ? (n1 == n2 + 4'd1) : (n1 == n2);
    board_changed = (board_p1 != snap_p1) || (board_p2 != snap_p2);
    snap_mine     = me ? snap_p2 : snap_p1;
    snap_theirs   = me ? snap_p1 : snap_p2;
    live_mine     = me ? board_p2 : board_p1;
    occ           = snap_p1 | snap_p2;
    fb_found      = 1'b0;
    fb_cell       = MOVE_NONE;
    for (int unsigned i = 0; i < 9; i++) begin
      if (!fb_found && !occ[FALLBACK_ORDER[i]]) begin
        fb_found = 1'b1;
        fb_cell  = FALLBACK_ORDER[i];
      end
    end
  end

  always_comb begin
    state_n       = state;
    line_idx_n    = line_idx;
    cnt_n         = cnt;
    snap_p1_n     = snap_p1;
    snap_p2_n     = snap_p2;
    me_n          = me;
    target_n      = target;
    move_idx_n    = move_idx;
    err_illegal_n = err_illegal;
    err_timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (!err_illegal) begin
          if (board_illegal) begin
            err_illegal_n = 1'b1;
          end else if (enable && my_turn && !game_over) begin
            snap_p1_n  = board_p1;
            snap_p2_n  = board_p2;
            me_n       = my_player;
            line_idx_n = '0;
            state_n    = SCAN_WIN;
          end
        end
      end
      SCAN_WIN, SCAN_BLOCK: begin
        if (game_over || board_changed) begin
          state_n = IDLE;
        end else if (hit) begin
          target_n   = empty_cell;
          move_idx_n = empty_cell;
          cnt_n      = '0;
          state_n    = PRESS;
        end else if (line_idx == 3'd7) begin
          line_idx_n = '0;
          state_n    = (state == SCAN_WIN) ? SCAN_BLOCK : FALLBACK;
        end else begin
          line_idx_n = line_idx + 3'd1;
        end
      end
      FALLBACK: begin
        if (game_over || board_changed) begin
          state_n = IDLE;
        end else if (fb_found) begin
          target_n   = fb_cell;
          move_idx_n = fb_cell;
          cnt_n      = '0;
          state_n    = PRESS;
        end else begin
          err_illegal_n = 1'b1;
          state_n       = IDLE;
        end
      end
      PRESS, GAP: begin
        if (cnt == PRESS_LAST) begin
          cnt_n   = '0;
          state_n = (state == PRESS) ? GAP : WAIT_ACK;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_ACK: begin
        if (game_over || live_mine[target]) begin
          state_n = IDLE;
        end else if (cnt == ACK_LAST) begin
          err_timeout_n = 1'b1;
          state_n       = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      line_idx    <= '0;
      cnt         <= '0;
      snap_p1     <= '0;
      snap_p2     <= '0;
      me          <= 1'b0;
      target      <= MOVE_NONE;
      move_idx    <= MOVE_NONE;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      line_idx    <= line_idx_n;
      cnt         <= cnt_n;
      snap_p1     <= snap_p1_n;
      snap_p2     <= snap_p2_n;
      me          <= me_n;
      target      <= target_n;
      move_idx    <= move_idx_n;
      err_illegal <= err_illegal_n;
      err_timeout <= err_timeout_n;
    end
  end

  // Decoded from the registered state so an async reset drops press at once.
  assign press = (state == PRESS) ? (9'b1 << target) : '0;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_ttt_auto_player.sv
// tb_ttt_auto_player: directed self-checking bench for ttt_auto_player.
module tb_ttt_auto_player;
  import ttt_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       my_player = 1'b0;
  logic [8:0] board_p1 = '0;
  logic [8:0] board_p2 = '0;
  logic       win_p1 = 1'b0;
  logic       win_p2 = 1'b0;
  logic       draw = 1'b0;
  logic [8:0] press;
  logic       busy;
  logic [3:0] move_idx;
  logic       err_illegal;
  logic       err_timeout;

  int passed = 0;
  int total  = 0;

  ttt_auto_player #(.PRESS_CYCLES(4), .ACK_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .my_player   (my_player),
    .board_p1    (board_p1),
    .board_p2    (board_p2),
    .win_p1      (win_p1),
    .win_p2      (win_p2),
    .draw        (draw),
    .press       (press),
    .busy        (busy),
    .move_idx    (move_idx),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents a position in IDLE cycle T with enable high; returns in cycle T+1.
  task automatic start(input logic [8:0] p1, input logic [8:0] p2, input logic player);
    board_p1  = p1;
    board_p2  = p2;
    my_player = player;
    enable    = 1'b1;
    step(1);
    enable    = 1'b0;
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_press", press, 0);
    chk("rst_busy", busy, 0);
    chk("rst_move_idx", move_idx, 4'hF);
    chk("rst_err_illegal", err_illegal, 0);
    chk("rst_err_timeout", err_timeout, 0);
    reset = 1'b1;
    step(1);

    // Empty board: no win/block, fallback picks centre at T+18..T+21
    start(9'h000, 9'h000, 1'b0);
    step(16);
    chk("fb_t17_press", press, 0);
    chk("fb_t17_busy", busy, 1);
    step(1);
    chk("fb_t18_press", press, 9'h010);
    chk("fb_t18_move_idx", move_idx, 4);
    step(3);
    chk("fb_t21_press", press, 9'h010);
    step(1);
    chk("fb_t22_press", press, 0);
    board_p1 = 9'h010;
    step(5);
    chk("fb_ack_busy", busy, 0);
    chk("fb_ack_err_timeout", err_timeout, 0);
    chk("fb_ack_err_illegal", err_illegal, 0);
    chk("fb_ack_move_idx", move_idx, 4);

    // Win on line 0: press cell 2 at T+2..T+5
    start(9'b000000011, 9'b000011000, 1'b0);
    chk("win_t1_press", press, 0);
    chk("win_t1_busy", busy, 1);
    step(1);
    chk("win_t2_press", press, 9'h004);
    chk("win_t2_move_idx", move_idx, 2);
    step(3);
    chk("win_t5_press", press, 9'h004);
    step(1);
    chk("win_t6_press", press, 0);
    board_p1 = 9'b000000111;
    step(5);
    chk("win_ack_busy", busy, 0);

    // Block on line 0 as P2: press cell 2 at T+10..T+13
    start(9'b000000011, 9'b000010000, 1'b1);
    step(8);
    chk("blk_t9_press", press, 0);
    chk("blk_t9_busy", busy, 1);
    step(1);
    chk("blk_t10_press", press, 9'h004);
    chk("blk_t10_move_idx", move_idx, 2);
    step(3);
    chk("blk_t13_press", press, 9'h004);
    step(1);
    chk("blk_t14_press", press, 0);
    board_p2 = 9'b000010100;
    step(5);
    chk("blk_ack_busy", busy, 0);
    chk("blk_ack_err_timeout", err_timeout, 0);

    // No acknowledge: 16 WAIT_ACK cycles T+10..T+25, err_timeout at T+26
    start(9'b000000011, 9'b000011000, 1'b0);
    step(24);
    chk("to_t25_busy", busy, 1);
    chk("to_t25_err_timeout", err_timeout, 0);
    step(1);
    chk("to_t26_err_timeout", err_timeout, 1);
    chk("to_t26_busy", busy, 0);
    step(1);
    chk("to_t27_err_timeout", err_timeout, 0);

    // Overlapping cell is illegal and sticky until reset
    board_p1 = 9'h008;
    board_p2 = 9'h008;
    enable   = 1'b1;
    step(1);
    chk("ill_flag", err_illegal, 1);
    chk("ill_press", press, 0);
    chk("ill_busy", busy, 0);
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(2);
    chk("ill_sticky", err_illegal, 1);
    chk("ill_sticky_busy", busy, 0);
    enable   = 1'b0;
    board_p1 = '0;
    board_p2 = '0;
    #2;
    reset = 1'b0;
    #1;
    chk("ill_clear", err_illegal, 0);
    #1;
    reset = 1'b1;
    step(1);

    // Async reset in the middle of PRESS
    start(9'b000000011, 9'b000011000, 1'b0);
    step(2);
    chk("rp_press_before", press, 9'h004);
    #2;
    reset = 1'b0;
    #1;
    chk("rp_press", press, 0);
    chk("rp_move_idx", move_idx, 4'hF);
    chk("rp_busy", busy, 0);
    #1;
    reset = 1'b1;
    step(1);

    // Game ends during SCAN_BLOCK: abort with no press
    start(9'b000000011, 9'b000010000, 1'b1);
    step(8);
    chk("go_t9_busy", busy, 1);
    win_p1 = 1'b1;
    step(1);
    chk("go_t10_busy", busy, 0);
    chk("go_t10_press", press, 0);
    step(4);
    chk("go_t14_press", press, 0);
    chk("go_move_idx", move_idx, 4'hF);
    win_p1 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
